// File: rtl/alu_decode_stage.sv
// Registered ALU decoder for the ID/EX boundary: RV32I ALU ops plus optional RV32M,
// with hazard stall/flush and an upstream hold while a multi-cycle M op drains.
module alu_decode_stage #(
   parameter int CONTROL_WIDTH = 5,
   parameter int M_EXT         = 1,
   parameter int MUL_LATENCY   = 1,
   parameter int DIV_LATENCY   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [2:0]               funct3,
   input  logic                     funct7b5,
   input  logic                     funct7b0,
   input  logic                     opb5,
   input  logic [1:0]               ALUOp,
   input  logic                     stall_i,
   input  logic                     flush_i,
   output logic                     valid_o,
   output logic [CONTROL_WIDTH-1:0] ALUControl,
   output logic                     illegal_o,
   output logic                     md_busy_o
);

   typedef enum logic {IDLE, MD_WAIT} state_t;

   localparam logic [3:0] MUL_L = 4'(MUL_LATENCY);
   localparam logic [3:0] DIV_L = 4'(DIV_LATENCY);

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic                     valid_q, valid_d;
   logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
   logic                     ill_q, ill_d;

   logic [4:0] dec_code;
   logic       dec_ill;
   logic       dec_m;
   logic [3:0] dec_lat;
   logic       accept;

   always_comb begin
      dec_code = 5'b00000;
      dec_ill  = 1'b0;
      dec_m    = 1'b0;
      unique case (ALUOp)
         2'b00: dec_code = 5'b00000;
         2'b01: dec_code = 5'b00001;
         2'b11: dec_ill  = 1'b1;
         default: begin
            // funct7b0 is an immediate bit on I-type, so only R-type can be an M op
            if (opb5 & funct7b0) begin
               if (M_EXT != 0) begin
                  dec_code = {2'b10, funct3};
                  dec_m    = 1'b1;
               end else begin
                  dec_ill  = 1'b1;
               end
            end else begin
               unique case (funct3)
                  3'b000:  dec_code = (funct7b5 & opb5) ? 5'b00001 : 5'b00000;
                  3'b001:  dec_code = 5'b00100;
                  3'b010:  dec_code = 5'b00101;
                  3'b011:  dec_code = 5'b01001;
                  3'b100:  dec_code = 5'b00110;
                  3'b101:  dec_code = funct7b5 ? 5'b01000 : 5'b00111;
                  3'b110:  dec_code = 5'b00011;
                  default: dec_code = 5'b00010;
               endcase
            end
         end
      endcase
   end

   assign dec_lat    = funct3[2] ? DIV_L : MUL_L;
   assign in_ready_o = (state_q == IDLE) & ~stall_i;
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      ill_d   = ill_q;
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         valid_d = 1'b0;
         ctrl_d  = '0;
         ill_d   = 1'b0;
      end else if (state_q == MD_WAIT) begin
         // counter runs regardless of stall; the M op stays on the outputs
         if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end else begin
            cnt_d   = cnt_q - 4'd1;
         end
      end else if (accept) begin
         valid_d = 1'b1;
         ctrl_d  = CONTROL_WIDTH'(dec_code);
         ill_d   = dec_ill;
         if (dec_m && (dec_lat > 4'd1)) begin
            state_d = MD_WAIT;
            cnt_d   = dec_lat - 4'd1;
         end
      end else if (!stall_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         ill_q   <= ill_d;
      end
   end

   assign valid_o    = valid_q;
   assign ALUControl = ctrl_q;
   assign illegal_o  = ill_q;
   assign md_busy_o  = (state_q == MD_WAIT);

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench: three configurations driven in lockstep against a behavioural model.
module tb_alu_decode_stage;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid_i = 1'b1;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b1, funct7b0 = 1'b0, opb5 = 1'b1;
   logic [1:0] ALUOp = 2'b10;
   logic       stall_i = 1'b0, flush_i = 1'b0;

   always #5 clk = ~clk;

   logic       a_rdy, a_vld, a_ill, a_busy;
   logic [4:0] a_ctrl;
   logic       b_rdy, b_vld, b_ill, b_busy;
   logic [4:0] b_ctrl;
   logic       c_rdy, c_vld, c_ill, c_busy;
   logic [6:0] c_ctrl;

   alu_decode_stage #(.CONTROL_WIDTH(5), .M_EXT(1), .MUL_LATENCY(1), .DIV_LATENCY(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(a_rdy),
      .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5), .ALUOp(ALUOp),
      .stall_i(stall_i), .flush_i(flush_i), .valid_o(a_vld), .ALUControl(a_ctrl),
      .illegal_o(a_ill), .md_busy_o(a_busy));

   alu_decode_stage #(.CONTROL_WIDTH(5), .M_EXT(0), .MUL_LATENCY(1), .DIV_LATENCY(8)) dut_b (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(b_rdy),
      .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5), .ALUOp(ALUOp),
      .stall_i(stall_i), .flush_i(flush_i), .valid_o(b_vld), .ALUControl(b_ctrl),
      .illegal_o(b_ill), .md_busy_o(b_busy));

   alu_decode_stage #(.CONTROL_WIDTH(7), .M_EXT(1), .MUL_LATENCY(3), .DIV_LATENCY(2)) dut_c (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(c_rdy),
      .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5), .ALUOp(ALUOp),
      .stall_i(stall_i), .flush_i(flush_i), .valid_o(c_vld), .ALUControl(c_ctrl),
      .illegal_o(c_ill), .md_busy_o(c_busy));

   localparam int MEXT[3] = '{1, 0, 1};
   localparam int MUL[3]  = '{1, 1, 3};
   localparam int DIV[3]  = '{8, 8, 2};

   typedef struct { bit vld; int ctrl; bit ill; int busy_left; } mstate_t;
   typedef struct { bit v; int c; bit i; bit b; bit r; } exp_t;

   mstate_t ms[3];
   exp_t q0[$], q1[$], q2[$];
   int checks = 0;
   int errors = 0;

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference decode written straight from the opcode tables
   function automatic void ref_decode(input int k, input bit [1:0] op, input bit [2:0] f3,
                                      input bit b5, input bit b0, input bit o5,
                                      output int code, output bit ill, output int lat);
      int tbl[8] = '{0, 4, 5, 9, 6, 7, 3, 2};
      code = 0; ill = 0; lat = 1;
      if (op == 2'd1) code = 1;
      else if (op == 2'd3) ill = 1;
      else if (op == 2'd2) begin
         if (o5 && b0) begin
            if (MEXT[k] == 1) begin
               code = 16 + f3;
               lat  = (f3 >= 4) ? DIV[k] : MUL[k];
            end else ill = 1;
         end else begin
            code = tbl[f3];
            if (f3 == 0 && b5 && o5) code = 1;
            if (f3 == 5 && b5) code = 8;
         end
      end
   endfunction

   function automatic mstate_t nxt(input int k, input mstate_t m, input bit v, input bit st,
                                   input bit fl, input bit [1:0] op, input bit [2:0] f3,
                                   input bit b5, input bit b0, input bit o5);
      mstate_t n = m;
      int code, lat;
      bit ill;
      if (fl) n = '{0, 0, 0, 0};
      else if (m.busy_left > 0) n.busy_left = m.busy_left - 1;
      else if (v && !st) begin
         ref_decode(k, op, f3, b5, b0, o5, code, ill, lat);
         n.vld = 1; n.ctrl = code; n.ill = ill;
         n.busy_left = (!ill && lat > 1) ? lat - 1 : 0;
      end else if (!st) n.vld = 0;
      return n;
   endfunction

   task automatic cyc(input bit r, input bit v, input bit st, input bit fl, input bit [1:0] op,
                      input bit [2:0] f3, input bit b5, input bit b0, input bit o5);
      exp_t e;
      @(posedge clk); #1;
      rst = r; in_valid_i = v; stall_i = st; flush_i = fl;
      ALUOp = op; funct3 = f3; funct7b5 = b5; funct7b0 = b0; opb5 = o5;
      for (int k = 0; k < 3; k++) begin
         if (r) ms[k] = '{0, 0, 0, 0};
         e.v = ms[k].vld; e.c = ms[k].ctrl; e.i = ms[k].ill;
         e.b = ms[k].busy_left > 0; e.r = (ms[k].busy_left == 0) && !st;
         if (k == 0) q0.push_back(e);
         else if (k == 1) q1.push_back(e);
         else q2.push_back(e);
         ms[k] = r ? '{0, 0, 0, 0} : nxt(k, ms[k], v, st, fl, op, f3, b5, b0, o5);
      end
   endtask

   task automatic check_one(input string id, input exp_t e, input bit v, input int c,
                            input bit i, input bit b, input bit r);
      cmp({id, ".valid_o"}, v, e.v);
      cmp({id, ".ALUControl"}, c, e.c);
      cmp({id, ".illegal_o"}, i, e.i);
      cmp({id, ".md_busy_o"}, b, e.b);
      cmp({id, ".in_ready_o"}, r, e.r);
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) check_one("a", q0.pop_front(), a_vld, int'(a_ctrl), a_ill, a_busy, a_rdy);
      if (q1.size() > 0) check_one("b", q1.pop_front(), b_vld, int'(b_ctrl), b_ill, b_busy, b_rdy);
      if (q2.size() > 0) check_one("c", q2.pop_front(), c_vld, int'(c_ctrl), c_ill, c_busy, c_rdy);
   end

   initial begin
      for (int k = 0; k < 3; k++) ms[k] = '{0, 0, 0, 0};
      // reset with an R-type sub presented, then release
      cyc(1, 1, 0, 0, 2'b10, 3'b000, 1, 0, 1);
      cyc(1, 1, 0, 0, 2'b10, 3'b000, 1, 0, 1);
      cyc(0, 1, 0, 0, 2'b10, 3'b000, 1, 0, 1);
      // funct3 sweep, I-type, both funct7b5 values
      for (int b = 0; b < 2; b++)
         for (int f = 0; f < 8; f++) cyc(0, 1, 0, 0, 2'b10, 3'(f), 1'(b), 1, 0);
      // div, wait it out, then a new instruction
      cyc(0, 1, 0, 0, 2'b10, 3'b100, 0, 1, 1);
      for (int n = 0; n < 9; n++) cyc(0, 1, 0, 0, 2'b10, 3'b110, 0, 0, 1);
      // div, flush with stall on the third MD_WAIT cycle
      cyc(0, 1, 0, 0, 2'b10, 3'b101, 0, 1, 1);
      cyc(0, 1, 0, 0, 2'b10, 3'b001, 0, 0, 1);
      cyc(0, 1, 0, 0, 2'b10, 3'b001, 0, 0, 1);
      cyc(0, 1, 1, 1, 2'b10, 3'b001, 0, 0, 1);
      cyc(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0);
      // add, two stall cycles, then reserved ALUOp
      cyc(0, 1, 0, 0, 2'b00, 3'b000, 0, 0, 0);
      cyc(0, 1, 1, 0, 2'b11, 3'b000, 0, 0, 0);
      cyc(0, 1, 1, 0, 2'b11, 3'b000, 0, 0, 0);
      cyc(0, 1, 0, 0, 2'b11, 3'b000, 0, 0, 0);
      // mul on the MUL_LATENCY=3 instance
      cyc(0, 1, 0, 0, 2'b10, 3'b000, 0, 1, 1);
      for (int n = 0; n < 4; n++) cyc(0, 1, 0, 0, 2'b01, 3'b000, 0, 0, 0);
      // reset in the middle of a div
      cyc(0, 1, 0, 0, 2'b10, 3'b110, 0, 1, 1);
      cyc(0, 1, 0, 0, 2'b10, 3'b000, 0, 0, 0);
      cyc(1, 1, 0, 0, 2'b10, 3'b000, 0, 0, 0);
      cyc(0, 1, 0, 0, 2'b10, 3'b000, 0, 0, 0);
      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         bit [1:0] op;
         op = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 3));
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, op,
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      @(negedge clk); #1;
      cmp("scoreboard_drain", q0.size() + q1.size() + q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Parametrised, registered successor to the pipeline's combinational ALU decoder.
- Decodes the full RV32I ALU op set and, optionally, RV32M mul/div/rem ops into a CONTROL_WIDTH-bit control word.
- Registers the control word into the ID/EX boundary and honours hazard-unit stall and flush.
- Holds upstream for a configurable number of cycles while a multi-cycle M-extension op is outstanding.

Parameters:
- CONTROL_WIDTH, 5: control word width. Must be >= 5. Bit 4 marks an M op; bits 3:0 carry the op code.
- M_EXT, 1: 1 enables RV32M decode. 0 flags any M op as illegal.
- MUL_LATENCY, 1: total cycles for mul* ops (funct3 0xx). Range 1..15.
- DIV_LATENCY, 8: total cycles for div/rem ops (funct3 1xx). Range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  decode-stage instruction valid.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- funct7b0  in  1  instruction bit 25.
- opb5  in  1  opcode bit 5 (1 = R-type).
- ALUOp  in  2  from the main decoder: 00 add, 01 sub, 10 funct-decoded, 11 reserved.
- stall_i  in  1  hazard-unit stall; hold the register.
- flush_i  in  1  hazard-unit flush; kill the register.
- valid_o  out  1  registered control is valid.
- ALUControl  out  CONTROL_WIDTH  registered control word.
- illegal_o  out  1  registered op was illegal.
- md_busy_o  out  1  multi-cycle M op in progress.

Behaviour:
- Combinational decode, ALUOp = 00: 00000 (add).
- ALUOp = 01: 00001 (sub).
- ALUOp = 11: 00000 with the illegal flag set.
- ALUOp = 10, M op (opb5 & funct7b0):
  - M_EXT = 1: code {1'b1, 1'b0, funct3}.
  - M_EXT = 0: code 00000 with the illegal flag set.
  - funct7b0 is ignored when opb5 = 0 (it is an immediate bit).
- ALUOp = 10, funct3 mapping:
  - 000: 00001 if funct7b5 & opb5, else 00000.
  - 001: 00100 (sll).
  - 010: 00101 (slt).
  - 011: 01001 (sltu).
  - 100: 00110 (xor).
  - 101: 01000 (sra) if funct7b5, else 00111 (srl). This applies to R- and I-type.
  - 110: 00011 (or).
  - 111: 00010 (and).
- Upper control bits beyond bit 4 are always 0.
- States: IDLE and MD_WAIT. in_ready_o = (state == IDLE) & ~stall_i.
- Accept = in_valid_i & in_ready_o.
- Register update priority, highest first:
  - rst (async): state IDLE, counter 0, all outputs 0.
  - flush_i: valid_o, ALUControl, illegal_o and counter go to 0; state IDLE. Flush overrides stall, accept and MD_WAIT.
  - Accept: load ALUControl and illegal_o; valid_o = 1.
  - Accepted legal M op with latency L > 1: counter = L-1, state MD_WAIT.
  - Stall with no accept: hold all registers.
  - IDLE, no stall, no accept: valid_o = 0; other registers hold.
- MD_WAIT:
  - Counter decrements every cycle, including while stall_i is high.
  - Return to IDLE in the cycle the counter reaches 1.
  - md_busy_o = (state == MD_WAIT), so it is high for exactly L-1 cycles.
  - valid_o and ALUControl hold the M op throughout. No new accept is possible.
- L = 1: no MD_WAIT; back-to-back accepts are allowed.
- An illegal op never enters MD_WAIT.
- Latency: ALUControl appears one cycle after accept.
- Reset asserted mid-MD_WAIT: immediate return to IDLE with all outputs 0.

Test Plan:
- Reset with rst = 1, then release; ALUOp = 10, funct3 = 000, funct7b5 = 1, opb5 = 1, in_valid_i = 1 -> outputs 0 during reset; next edge after release ALUControl = 00001, valid_o = 1.
- Sweep all funct3 with ALUOp = 10, opb5 = 0 -> codes 00000, 00100, 00101, 01001, 00110, 00111 (or 01000 with funct7b5 = 1), 00011, 00010.
- DIV_LATENCY = 8, accept div (opb5 = 1, funct7b0 = 1, funct3 = 100):
  - ALUControl = 10100.
  - md_busy_o high for 7 cycles; in_ready_o low for those 7 cycles.
  - Next instruction is accepted on cycle 8.
- M_EXT = 0, same div stimulus -> illegal_o = 1, ALUControl = 0, md_busy_o stays 0.
- flush_i on cycle 3 of MD_WAIT with stall_i = 1 -> next cycle valid_o = 0, md_busy_o = 0, in_ready_o = 1.
- stall_i held 2 cycles after accepting an add -> ALUControl and valid_o hold; ALUOp = 11 accepted afterwards -> illegal_o = 1.
